branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Sequences the 2-bit branch predictor across the ID→EX gap. Queues each prediction made in ID; when EX resolves the oldest branch, it issues the predictor update strobe and detects mispredicts. On a mispredict it raises a one-cycle flush with the corrected PC for the IF/ID/EX hazard logic. Sits between the decode stage, the predictor and the PC-select mux.

Parameters:
DEPTH, 2, max outstanding predicted branches, ≥1
PC_W, 32, PC width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  async reset, active-low
pred_valid_i  in  1  ID branch decoded and predictor sampled this cycle
pred_taken_i  in  1  predictor decision (predict_o)
pred_target_i  in  PC_W  branch target address
pred_fallthru_i  in  PC_W  PC+4 of the branch
pred_ready_o  out  1  queue can accept; 0 → ID must stall
res_valid_i  in  1  EX resolved oldest outstanding branch
res_taken_i  in  1  actual outcome
upd_valid_o  out  1  one-cycle strobe to predictor (drives branch_i)
upd_taken_o  out  1  actual outcome to predictor (drives update_i)
flush_o  out  1  one-cycle mispredict flush
redirect_pc_o  out  PC_W  corrected fetch PC, valid when flush_o=1
count_o  out  clog2(DEPTH+1)  outstanding entries
err_o  out  1  sticky: resolution arrived with empty queue

Behaviour:
- Reset (rst_i=0, async): queue empty, count_o=0, state RUN; upd_valid_o, upd_taken_o, flush_o, err_o=0; redirect_pc_o=0. pred_ready_o=1 during and after reset.
- Queue: in-order FIFO, entry = {taken, target, fallthru}; circular read/write pointers wrapping at DEPTH.
- pred_ready_o = (count < DEPTH) && (state==RUN); combinational from registers only, no bypass from same-cycle pop. Full and popping same cycle → still not ready.
- Push: pred_valid_i && pred_ready_o at a rising edge.
- Pop: res_valid_i && count>0. Outputs registered, latency 1: on the next cycle upd_valid_o=1, upd_taken_o=res_taken_i.
- Mispredict = head.taken != res_taken_i. The cycle after: flush_o=1, redirect_pc_o = res_taken_i ? head.target : head.fallthru. Correct prediction: flush_o=0, redirect_pc_o holds its last value.
- FSM: RUN → FLUSH on a mispredicting pop; FLUSH → RUN unconditionally after one cycle. flush_o is 1 exactly in FLUSH.
- Mispredict edge: entire queue cleared (count→0, pointers reset); any same-cycle push dropped (wrong path).
- In FLUSH: pred_ready_o=0, pushes ignored; res_valid_i ignored (no pop, no update, no err).
- Push and pop same edge (RUN, no mispredict): count unchanged, both pointers advance.
- res_valid_i with count=0 in RUN: no pop, upd_valid_o stays 0, err_o←1. Cleared only by reset.
- pred_valid_i while pred_ready_o=0: ignored; upstream holds it.
- Reset mid-operation: queue and FSM discarded immediately; no update strobe emitted afterwards.

Optional Feature:
Macro BRC_STATS_EN. When defined, adds two outputs: br_cnt_o[31:0] (+1 per pop) and mispred_cnt_o[31:0] (+1 per mispredicting pop). Both reset to 0, saturate at 0xFFFFFFFF, and change one cycle after the pop, aligned with upd_valid_o. When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release, idle → pred_ready_o=1, count_o=0, all strobes 0, err_o=0.
- Push {taken=1, tgt=0x100, ft=0x24}; resolve res_taken=1 next cycle → next cycle upd_valid_o=1, upd_taken_o=1, flush_o=0, count_o=0.
- Push {taken=1, tgt=0x200, ft=0x44}, push a second entry; resolve oldest res_taken=0 → next cycle flush_o=1, redirect_pc_o=0x44, upd_taken_o=0, count_o=0. The second entry is discarded and a push during FLUSH is ignored.
- DEPTH=2: push twice → pred_ready_o=0. Push+resolve same cycle while full → push refused, count_o=1 after the edge. Later pushes wrap the pointers and FIFO order is preserved.
- res_valid_i with empty queue → err_o=1 and stays 1, upd_valid_o=0. Async reset low → err_o=0 immediately.
- BRC_STATS_EN: 3 pops with 1 mispredict → br_cnt_o=3, mispred_cnt_o=1. Preload a counter to 0xFFFFFFFF → it holds at 0xFFFFFFFF on the next pop.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Decode/execute-side handshake bundle for branch_resolve_ctrl.
// master = ID/EX stage side, slave = the resolve controller.
interface branch_resolve_ctrl_if #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             pred_valid_i;
   logic             pred_taken_i;
   logic [PC_W-1:0]  pred_target_i;
   logic [PC_W-1:0]  pred_fallthru_i;
   logic             pred_ready_o;
   logic             res_valid_i;
   logic             res_taken_i;
   logic             upd_valid_o;
   logic             upd_taken_o;
   logic             flush_o;
   logic [PC_W-1:0]  redirect_pc_o;
   logic [CNT_W-1:0] count_o;
   logic             err_o;

   modport master (
      output pred_valid_i, pred_taken_i, pred_target_i, pred_fallthru_i,
      output res_valid_i, res_taken_i,
      input  pred_ready_o, upd_valid_o, upd_taken_o, flush_o,
      input  redirect_pc_o, count_o, err_o
   );

   modport slave (
      input  pred_valid_i, pred_taken_i, pred_target_i, pred_fallthru_i,
      input  res_valid_i, res_taken_i,
      output pred_ready_o, upd_valid_o, upd_taken_o, flush_o,
      output redirect_pc_o, count_o, err_o
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight branch predictions from ID to EX, strobes predictor updates
// and raises a one-cycle flush on mispredict. BRC_STATS_EN adds pop/mispredict counters.
module branch_resolve_ctrl #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   branch_resolve_ctrl_if.slave bus
`ifdef BRC_STATS_EN
   ,
   output logic [31:0] br_cnt_o,
   output logic [31:0] mispred_cnt_o
`endif
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef struct packed {
      logic            taken;
      logic [PC_W-1:0] target;
      logic [PC_W-1:0] fallthru;
   } brc_entry_t;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t           state_q, state_d;
   brc_entry_t       q_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt_q;
   logic             upd_valid_q, upd_taken_q, err_q;
   logic [PC_W-1:0]  redirect_q;

   logic       pred_ready, push, pop, mispred;
   brc_entry_t head;

   assign head       = q_mem[rd_ptr];
   assign pred_ready = (cnt_q < CNT_W'(DEPTH)) && (state_q == RUN);
   assign push       = bus.pred_valid_i && pred_ready;
   assign pop        = (state_q == RUN) && bus.res_valid_i && (cnt_q != '0);
   assign mispred    = pop && (head.taken != bus.res_taken_i);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (mispred) state_d = FLUSH;
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (push) q_mem[wr_ptr] <= '{taken: bus.pred_taken_i, target: bus.pred_target_i,
                                    fallthru: bus.pred_fallthru_i};
   end

   // A mispredict discards everything younger, including a same-edge push.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (mispred) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         upd_valid_q <= 1'b0;
         upd_taken_q <= 1'b0;
         redirect_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         upd_valid_q <= pop;
         if (pop)     upd_taken_q <= bus.res_taken_i;
         if (mispred) redirect_q  <= bus.res_taken_i ? head.target : head.fallthru;
         if ((state_q == RUN) && bus.res_valid_i && (cnt_q == '0)) err_q <= 1'b1;
      end
   end

   assign bus.pred_ready_o  = pred_ready;
   assign bus.upd_valid_o   = upd_valid_q;
   assign bus.upd_taken_o   = upd_taken_q;
   assign bus.flush_o       = (state_q == FLUSH);
   assign bus.redirect_pc_o = redirect_q;
   assign bus.count_o       = cnt_q;
   assign bus.err_o         = err_q;

`ifdef BRC_STATS_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         br_cnt_o      <= '0;
         mispred_cnt_o <= '0;
      end else begin
         if (pop && (br_cnt_o != '1))          br_cnt_o      <= br_cnt_o + 1'b1;
         if (mispred && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus random traffic against a queue model.
module tb_branch_resolve_ctrl;
   localparam int DEPTH = 2;
   localparam int PC_W  = 32;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   branch_resolve_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bif ();
`ifdef BRC_STATS_EN
   logic [31:0] br_cnt_o, mispred_cnt_o;
`endif

   branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bif.slave)
`ifdef BRC_STATS_EN
      ,
      .br_cnt_o     (br_cnt_o),
      .mispred_cnt_o(mispred_cnt_o)
`endif
   );

   typedef struct {
      logic        taken;
      logic [31:0] tgt;
      logic [31:0] ft;
   } ent_t;

   int total = 0;
   int bad   = 0;

   // reference model state
   ent_t        mq[$];
   logic        m_flush, m_err, m_uv, m_ut, m_ready;
   logic [31:0] m_redir;
   logic        pre_ready;

   task automatic model_reset();
      mq.delete();
      m_flush = 0; m_err = 0; m_uv = 0; m_ut = 0; m_redir = 0; m_ready = 1;
   endtask

   task automatic idle_inputs();
      bif.pred_valid_i = 0; bif.pred_taken_i = 0;
      bif.pred_target_i = 0; bif.pred_fallthru_i = 0;
      bif.res_valid_i = 0; bif.res_taken_i = 0;
   endtask

   // Drive one cycle of inputs, advance the model, and stop 1ns after the edge.
   task automatic step(input logic pv, input logic pt, input logic [31:0] tg,
                       input logic [31:0] ft, input logic rv, input logic rt);
      ent_t h;
      logic do_push;
      bif.pred_valid_i = pv; bif.pred_taken_i = pt;
      bif.pred_target_i = tg; bif.pred_fallthru_i = ft;
      bif.res_valid_i = rv; bif.res_taken_i = rt;
      #1;
      pre_ready = bif.pred_ready_o;
      m_ready   = !m_flush && (mq.size() < DEPTH);
      do_push   = pv && m_ready;
      m_uv      = 0;
      if (!m_flush && rv) begin
         if (mq.size() == 0) m_err = 1;
         else begin
            h    = mq.pop_front();
            m_uv = 1;
            m_ut = rt;
            if (h.taken != rt) begin
               m_flush = 1;
               m_redir = rt ? h.tgt : h.ft;
               mq.delete();
               do_push = 0;
            end else m_flush = 0;
         end
      end else m_flush = 0;
      if (do_push) mq.push_back('{taken: pt, tgt: tg, ft: ft});
      @(posedge clk_i);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      model_reset();
      #12;
      total++; if (bif.pred_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready_during got=%0b exp=1", bif.pred_ready_o); end
      @(negedge clk_i); rst_i = 1;
      @(posedge clk_i); #1;
      total++; if (bif.pred_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", bif.pred_ready_o); end
      total++; if (bif.count_o !== 0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bif.count_o); end
      total++; if ({bif.upd_valid_o, bif.upd_taken_o, bif.flush_o, bif.err_o} !== 4'b0) begin
         bad++; $display("FAIL rst_strobes got=%b exp=0000", {bif.upd_valid_o, bif.upd_taken_o, bif.flush_o, bif.err_o}); end
      total++; if (bif.redirect_pc_o !== 0) begin bad++; $display("FAIL rst_redirect got=%h exp=0", bif.redirect_pc_o); end
   endtask

   task automatic test_correct();
      step(1, 1, 32'h100, 32'h24, 0, 0);
      total++; if (bif.count_o !== 1) begin bad++; $display("FAIL corr_count1 got=%0d exp=1", bif.count_o); end
      step(0, 0, 0, 0, 1, 1);
      total++; if ({bif.upd_valid_o, bif.upd_taken_o, bif.flush_o} !== 3'b110) begin
         bad++; $display("FAIL corr_upd got=%b exp=110", {bif.upd_valid_o, bif.upd_taken_o, bif.flush_o}); end
      total++; if (bif.count_o !== 0) begin bad++; $display("FAIL corr_count0 got=%0d exp=0", bif.count_o); end
   endtask

   task automatic test_mispredict();
      step(1, 1, 32'h200, 32'h44, 0, 0);
      step(1, 0, 32'h300, 32'h64, 0, 0);
      total++; if (bif.count_o !== 2) begin bad++; $display("FAIL mis_count2 got=%0d exp=2", bif.count_o); end
      step(1, 1, 32'h400, 32'h84, 1, 0);
      total++; if ({bif.flush_o, bif.upd_valid_o, bif.upd_taken_o} !== 3'b110) begin
         bad++; $display("FAIL mis_flush got=%b exp=110", {bif.flush_o, bif.upd_valid_o, bif.upd_taken_o}); end
      total++; if (bif.redirect_pc_o !== 32'h44) begin bad++; $display("FAIL mis_redirect got=%h exp=44", bif.redirect_pc_o); end
      total++; if (bif.count_o !== 0 || bif.pred_ready_o !== 0) begin
         bad++; $display("FAIL mis_cleared count=%0d ready=%0b exp=0/0", bif.count_o, bif.pred_ready_o); end
      step(1, 1, 32'h500, 32'ha4, 1, 1);
      total++; if ({bif.flush_o, bif.upd_valid_o, bif.err_o} !== 3'b000 || bif.count_o !== 0) begin
         bad++; $display("FAIL mis_flush_ignore got=%b count=%0d exp=000/0", {bif.flush_o, bif.upd_valid_o, bif.err_o}, bif.count_o); end
      total++; if (bif.redirect_pc_o !== 32'h44) begin bad++; $display("FAIL mis_redirect_hold got=%h exp=44", bif.redirect_pc_o); end
   endtask

   task automatic test_full_wrap();
      step(1, 0, 32'h600, 32'h11, 0, 0);
      step(1, 1, 32'h700, 32'h22, 0, 0);
      total++; if (bif.pred_ready_o !== 0) begin bad++; $display("FAIL full_ready got=%b exp=0", bif.pred_ready_o); end
      step(1, 1, 32'h800, 32'h33, 1, 0);
      total++; if (pre_ready !== 0) begin bad++; $display("FAIL full_pop_ready got=%b exp=0", pre_ready); end
      total++; if (bif.count_o !== 1 || bif.upd_valid_o !== 1) begin
         bad++; $display("FAIL full_pushpop count=%0d upd=%b exp=1/1", bif.count_o, bif.upd_valid_o); end
      step(1, 0, 32'h900, 32'h55, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      total++; if (bif.flush_o !== 0 || bif.count_o !== 1) begin
         bad++; $display("FAIL wrap_b flush=%b count=%0d exp=0/1", bif.flush_o, bif.count_o); end
      step(0, 0, 0, 0, 1, 1);
      total++; if (bif.flush_o !== 1 || bif.redirect_pc_o !== 32'h900) begin
         bad++; $display("FAIL wrap_order flush=%b pc=%h exp=1/900", bif.flush_o, bif.redirect_pc_o); end
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_err();
      step(0, 0, 0, 0, 1, 0);
      total++; if (bif.err_o !== 1 || bif.upd_valid_o !== 0) begin
         bad++; $display("FAIL err_set err=%b upd=%b exp=1/0", bif.err_o, bif.upd_valid_o); end
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      total++; if (bif.err_o !== 1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bif.err_o); end
   endtask

   task automatic test_async_reset();
      step(1, 1, 32'hA00, 32'hB00, 0, 0);
      bif.res_valid_i = 1; bif.res_taken_i = 0;
      #2 rst_i = 0;
      #1;
      model_reset();
      total++; if (bif.err_o !== 0 || bif.count_o !== 0 || bif.pred_ready_o !== 1) begin
         bad++; $display("FAIL async_rst err=%b count=%0d ready=%b exp=0/0/1", bif.err_o, bif.count_o, bif.pred_ready_o); end
      @(posedge clk_i); #1;
      idle_inputs();
      #2 rst_i = 1;
      @(posedge clk_i); #1;
      total++; if (bif.upd_valid_o !== 0 || bif.flush_o !== 0 || bif.count_o !== 0) begin
         bad++; $display("FAIL async_no_upd upd=%b flush=%b count=%0d exp=0/0/0", bif.upd_valid_o, bif.flush_o, bif.count_o); end
   endtask

`ifdef BRC_STATS_EN
   task automatic test_stats();
      step(1, 1, 32'h10, 32'h14, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      step(1, 0, 32'h20, 32'h24, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 1, 32'h30, 32'h34, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      total++; if (br_cnt_o !== 3 || mispred_cnt_o !== 1) begin
         bad++; $display("FAIL stats br=%0d mis=%0d exp=3/1", br_cnt_o, mispred_cnt_o); end
      step(0, 0, 0, 0, 0, 0);
   endtask
`endif

   task automatic test_random();
      logic pv, rv;
      for (int i = 0; i < 400; i++) begin
         pv = ($urandom_range(0, 99) < 55);
         rv = ($urandom_range(0, 99) < 40);
         step(pv, 1'($urandom), $urandom, $urandom, rv, 1'($urandom));
         total++; if (pre_ready !== m_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, pre_ready, m_ready); end
         total++; if (bif.upd_valid_o !== m_uv || (m_uv && bif.upd_taken_o !== m_ut)) begin
            bad++; $display("FAIL rnd_upd cyc=%0d got=%b%b exp=%b%b", i, bif.upd_valid_o, bif.upd_taken_o, m_uv, m_ut); end
         total++; if (bif.flush_o !== m_flush || bif.redirect_pc_o !== m_redir) begin
            bad++; $display("FAIL rnd_flush cyc=%0d got=%b/%h exp=%b/%h", i, bif.flush_o, bif.redirect_pc_o, m_flush, m_redir); end
         total++; if (bif.count_o !== 2'(mq.size()) || bif.err_o !== m_err) begin
            bad++; $display("FAIL rnd_state cyc=%0d count=%0d err=%b exp=%0d/%b", i, bif.count_o, bif.err_o, mq.size(), m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_correct();
      test_mispredict();
      test_full_wrap();
      test_err();
      test_async_reset();
`ifdef BRC_STATS_EN
      test_stats();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
